fbus_reset_sequencer: RTL and testbench

- Consumes the member_subsystem_fbus_0 clock/reset pair produced by the fbus clock-group aggregation stage.
- Delivers a synchronized, stretched, sequenced active-low reset to front-bus logic.
- Supports a software-requested domain reset that first quiesces the front bus through a req/ack handshake, with a timeout fallback.
- Sits between the fbus clock-group output and the fbus crossing/buffer logic.

---
 rtl/fbus_rst_pkg.sv | 23 ++
 rtl/fbus_reset_sync.sv | 23 ++
 rtl/fbus_reset_sequencer.sv | 125 ++++++++++++
 tb/tb_fbus_reset_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fbus_rst_pkg.sv
// Shared types and counter-width helpers for the fbus reset sequencer.
// State encoding is visible on state_o, so the enum values are fixed.
package fbus_rst_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2,
    QUIESCE = 2'd3
  } fbus_state_e;

  localparam int unsigned DEF_STRETCH_CYCLES = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned STRETCH_W_DEF = cnt_width(DEF_STRETCH_CYCLES);
  localparam int unsigned TIMEOUT_W_DEF = cnt_width(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/fbus_reset_sync.sv
// Reset bridge: asserts rst_sync low asynchronously, releases it only after
// SYNC_STAGES clean clock edges so deassertion is metastability-safe.
module fbus_reset_sync #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic clock,
  input  logic reset,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fbus_reset_sequencer.sv
// Sequenced, stretched front-bus reset with a software reset path that drains
// the bus via quiesce_req/quiesce_ack (or a timeout) before re-asserting reset.
module fbus_reset_sequencer
  import fbus_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sw_reset_req,
  input  logic             quiesce_ack,
  output logic             fbus_reset_n,
  output logic             fbus_ready,
  output logic             quiesce_req,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] sw_reset_count,
  output logic [1:0]       state_o
);

  localparam int unsigned SW = cnt_width(STRETCH_CYCLES);
  localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [SW-1:0]    STRETCH_LAST = SW'(STRETCH_CYCLES - 1);
  localparam logic [TW-1:0]    TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX    = '1;

  logic             rst_sync;
  fbus_state_e      state_q, state_d;
  logic [SW-1:0]    stretch_cnt_q, stretch_cnt_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             req_q;
  logic             rstn_q;
  logic             quiesce_q;
  logic             sw_rise;

  fbus_reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .rst_sync (rst_sync)
  );

  // Edge detector runs in every state; rises outside RUN are simply dropped.
  assign sw_rise = sw_reset_req & ~req_q;

  always_comb begin
    state_d       = state_q;
    stretch_cnt_d = stretch_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    flag_d        = flag_q;
    count_d       = count_q;
    case (state_q)
      ASSERT: begin
        if (rst_sync) begin
          state_d       = STRETCH;
          stretch_cnt_d = '0;
        end
      end
      STRETCH: begin
        if (stretch_cnt_q == STRETCH_LAST) begin
          state_d = RUN;
        end else begin
          stretch_cnt_d = stretch_cnt_q + SW'(1);
        end
      end
      RUN: begin
        if (sw_rise) begin
          state_d   = QUIESCE;
          tmo_cnt_d = '0;
          flag_d    = 1'b0;
          if (count_q != COUNT_MAX) begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      QUIESCE: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (quiesce_ack) begin
          state_d = ASSERT;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ASSERT;
          flag_d  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ASSERT;
      stretch_cnt_q <= '0;
      tmo_cnt_q     <= '0;
      flag_q        <= 1'b0;
      count_q       <= '0;
      req_q         <= 1'b0;
      rstn_q        <= 1'b0;
      quiesce_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      stretch_cnt_q <= stretch_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      flag_q        <= flag_d;
      count_q       <= count_d;
      req_q         <= sw_reset_req;
      // Outputs decode the next state so they switch with the state flop, glitch-free.
      rstn_q        <= (state_d == RUN) || (state_d == QUIESCE);
      quiesce_q     <= (state_d == QUIESCE);
    end
  end

  assign fbus_reset_n   = rstn_q;
  assign fbus_ready     = rstn_q;
  assign quiesce_req    = quiesce_q;
  assign timeout_flag   = flag_q;
  assign sw_reset_count = count_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_fbus_reset_sequencer.sv
// Bench for fbus_reset_sequencer: a vector table, directed multi-cycle corner cases,
// then random stimulus checked each cycle against a timestamp-based reference model.
module tb_fbus_reset_sequencer;

  localparam int SYNC    = 3;
  localparam int STRETCH = 16;
  localparam int TIMEOUT = 1024;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sw_reset_req = 1'b0;
  logic       quiesce_ack = 1'b0;
  logic       rstn_a, ready_a, qreq_a, flag_a;
  logic [7:0] cnt_a;
  logic [1:0] st_a;
  logic       rstn_b, ready_b, qreq_b, flag_b;
  logic [1:0] cnt_b;
  logic [1:0] st_b;

  int n_pass = 0;
  int n_total = 0;
  bit model_en = 1'b0;

  always #5 clock = ~clock;

  fbus_reset_sequencer dut_a (
    .clock(clock), .reset(reset), .sw_reset_req(sw_reset_req), .quiesce_ack(quiesce_ack),
    .fbus_reset_n(rstn_a), .fbus_ready(ready_a), .quiesce_req(qreq_a),
    .timeout_flag(flag_a), .sw_reset_count(cnt_a), .state_o(st_a)
  );

  fbus_reset_sequencer #(.CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .sw_reset_req(sw_reset_req), .quiesce_ack(quiesce_ack),
    .fbus_reset_n(rstn_b), .fbus_ready(ready_b), .quiesce_req(qreq_b),
    .timeout_flag(flag_b), .sw_reset_count(cnt_b), .state_o(st_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: tracks edge timestamps of phase boundaries instead of a state machine.
  int t, stretch_from, run_from, q_start, m_cnt_a, m_cnt_b;
  bit quiescing, prev_req, m_flag;

  function automatic int mstate();
    if (t < stretch_from) return 0;
    if (t < run_from) return 1;
    return quiescing ? 3 : 2;
  endfunction

  always @(posedge clock or negedge reset) begin
    int cur;
    bit rise;
    if (!reset) begin
      t = 0; stretch_from = SYNC + 1; run_from = SYNC + 1 + STRETCH;
      quiescing = 0; prev_req = 0; m_flag = 0; m_cnt_a = 0; m_cnt_b = 0; q_start = 0;
    end else begin
      cur = mstate();
      rise = sw_reset_req && !prev_req;
      prev_req = sw_reset_req;
      t++;
      if (cur == 3) begin
        if (quiesce_ack || (t - q_start) == TIMEOUT) begin
          if (!quiesce_ack) m_flag = 1;
          quiescing = 0;
          stretch_from = t + 1;
          run_from = t + 1 + STRETCH;
        end
      end else if (cur == 2 && rise) begin
        quiescing = 1; q_start = t; m_flag = 0;
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end
    end
  end

  always @(negedge clock) begin
    int ms;
    if (model_en) begin
      ms = mstate();
      check("model_a", {st_a, rstn_a, ready_a, qreq_a, flag_a, cnt_a},
            {2'(ms), ms >= 2, ms >= 2, ms == 3, m_flag, 8'(m_cnt_a)});
      check("model_b", {st_b, rstn_b, ready_b, qreq_b, flag_b, cnt_b},
            {2'(ms), ms >= 2, ms >= 2, ms == 3, m_flag, 2'(m_cnt_b)});
    end
  end

  typedef struct {
    int         cycles;
    bit         req;
    bit         ack;
    logic [1:0] st;
    bit         rstn;
    bit         qreq;
    bit         flag;
    int         cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_req();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
  endtask

  task automatic ack_now();
    quiesce_ack = 1'b1;
    tick();
    quiesce_ack = 1'b0;
  endtask

  task automatic wait_for(input string name, input logic [1:0] st, input int max);
    for (int i = 0; i < max && st_a !== st; i++) tick();
    check(name, st_a, st);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int q_high;
    #1 reset = 1'b0;
    model_en = 1'b1;
    // Power-on: reset low for 5 cycles; vectors count edges from the release.
    tbl[0]  = '{3,   0, 0, 2'd0, 0, 0, 0, 0};
    tbl[1]  = '{1,   0, 0, 2'd1, 0, 0, 0, 0};
    tbl[2]  = '{15,  0, 0, 2'd1, 0, 0, 0, 0};
    tbl[3]  = '{1,   0, 0, 2'd2, 1, 0, 0, 0};
    tbl[4]  = '{5,   0, 1, 2'd2, 1, 0, 0, 0};
    tbl[5]  = '{1,   1, 0, 2'd3, 1, 1, 0, 1};
    tbl[6]  = '{7,   1, 0, 2'd3, 1, 1, 0, 1};
    tbl[7]  = '{1,   1, 1, 2'd0, 0, 0, 0, 1};
    tbl[8]  = '{1,   1, 0, 2'd1, 0, 0, 0, 1};
    tbl[9]  = '{15,  1, 0, 2'd1, 0, 0, 0, 1};
    tbl[10] = '{1,   1, 0, 2'd2, 1, 0, 0, 1};
    tbl[11] = '{180, 1, 0, 2'd2, 1, 0, 0, 1};
    tbl[12] = '{2,   0, 0, 2'd2, 1, 0, 0, 1};

    repeat (5) @(posedge clock);
    #1;
    check("reset_state", {st_a, rstn_a, ready_a, qreq_a, flag_a, cnt_a}, 14'd0);
    release_reset();
    for (int i = 0; i < 13; i++) begin
      sw_reset_req = tbl[i].req;
      quiesce_ack  = tbl[i].ack;
      repeat (tbl[i].cycles) @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), {st_a, rstn_a, ready_a, qreq_a, flag_a, cnt_a},
            {tbl[i].st, tbl[i].rstn, tbl[i].rstn, tbl[i].qreq, tbl[i].flag, 8'(tbl[i].cnt)});
    end
    quiesce_ack = 1'b0;

    // Timeout: no ack ever.
    pulse_req();
    q_high = 0;
    while (qreq_a === 1'b1 && q_high < 2000) begin
      q_high++;
      tick();
    end
    check("tmo_qreq_len", q_high, TIMEOUT);
    check("tmo_rstn_low", rstn_a, 1'b0);
    check("tmo_flag", flag_a, 1'b1);
    wait_for("tmo_back_run", 2'd2, 40);
    check("tmo_flag_sticky", flag_a, 1'b1);
    check("tmo_count", cnt_a, 8'd2);

    // Ack lands on the final timeout cycle: ack wins, flag cleared on entry stays 0.
    pulse_req();
    check("coin_flag_cleared", flag_a, 1'b0);
    repeat (TIMEOUT - 1) @(posedge clock);
    #1;
    check("coin_still_qreq", qreq_a, 1'b1);
    ack_now();
    check("coin_state", st_a, 2'd0);
    check("coin_flag", flag_a, 1'b0);
    wait_for("coin_back_run", 2'd2, 40);

    // A request during STRETCH must be dropped.
    pulse_req();
    ack_now();
    tick();
    check("stretch_state", st_a, 2'd1);
    pulse_req();
    wait_for("stretch_back_run", 2'd2, 40);
    repeat (3) tick();
    check("stretch_ignored_cnt", cnt_a, 8'd4);
    check("stretch_ignored_st", st_a, 2'd2);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      wait_for("sat_run", 2'd2, 40);
      pulse_req();
      ack_now();
    end
    wait_for("sat_final_run", 2'd2, 40);
    check("sat_cnt_b", cnt_b, 2'd3);
    check("sat_cnt_a", cnt_a, 8'd9);

    // Asynchronous reset in the middle of a quiesce, between clock edges.
    pulse_req();
    check("async_in_quiesce", qreq_a, 1'b1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_outputs", {st_a, rstn_a, ready_a, qreq_a, flag_a, cnt_a}, 14'd0);
    check("async_cnt_b", cnt_b, 2'd0);
    repeat (2) @(posedge clock);
    release_reset();
    repeat (19) @(posedge clock);
    #1;
    check("async_edge19_low", rstn_a, 1'b0);
    tick();
    check("async_edge20_high", {st_a, rstn_a}, {2'd2, 1'b1});

    // Random stimulus; the model checker compares every cycle.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(5) == 0) sw_reset_req = ~sw_reset_req;
      quiesce_ack = ($urandom_range(7) == 0);
      if ($urandom_range(1999) == 0) begin
        #2 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
